serial_bus_top: RTL and testbench

- Self-contained demo of a bit-serial shared bus: two masters, an arbiter and three 16x8 memory slaves.
- Transactions are configured from a 12-bit switch array and launched by push buttons.
- All bus activity advances on a divided-clock tick; only the master busy flags and the divided clock are visible at the ports.

---
 rtl/serial_bus_top.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_serial_bus_top.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_top.sv
// serial_bus_top
//   Demo of a bit-serial shared bus: two masters, a fixed-priority arbiter
//   and three 16x8 memory slaves. Transactions are configured from the
//   switch array and launched by push buttons. Every bus bit-time is one
//   divider tick; all logic is clocked by 'clock' and qualified by tick.
//
// Ports
//   clock         system clock, rising edge
//   rst           asynchronous active-high reset
//   enable        1 = divider runs, 0 = everything frozen
//   button1_raw   master-1 start (active-low)
//   button2_raw   master-2 start (active-low)
//   button3_raw   config step (active-low)
//   mode_switch   0 = config mode, 1 = run mode
//   rw_switch1/2  master direction: 0 write, 1 read
//   switch_array  config value
//   m1_busy/m2_busy  master transaction pending or active
//   scaled_clk    divided clock, period SCALE clocks
`timescale 1ns/1ps

module serial_bus_top #(
  parameter int SCALE = 10
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic        button1_raw,
  input  logic        button2_raw,
  input  logic        button3_raw,
  input  logic        mode_switch,
  input  logic        rw_switch1,
  input  logic        rw_switch2,
  input  logic [11:0] switch_array,
  output logic        m1_busy,
  output logic        m2_busy,
  output logic        scaled_clk
);

  localparam int CNT_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCALE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCALE / 2);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} arb_state_t;

  // divider
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // buttons and configuration registers
  logic [2:0]  btn_now, btn_press, btn_prev_q, btn_prev_d;
  logic [2:0]  idx_q, idx_d;
  logic [11:0] cfg_q [7];
  logic [11:0] cfg_d [7];

  // per-master transaction registers, index 0 = M1, 1 = M2
  logic [1:0]  busy_q, busy_d;
  logic [1:0]  rw_q, rw_d;
  logic [1:0]  rw_in;
  logic [3:0]  addr_q [2];
  logic [3:0]  addr_d [2];
  logic [7:0]  wdata_q [2];
  logic [7:0]  wdata_d [2];
  logic [1:0]  sel_q [2];
  logic [1:0]  sel_d [2];
  logic [3:0]  len_q [2];
  logic [3:0]  len_d [2];
  logic [7:0]  rdata_q [2];
  logic [7:0]  rdata_d [2];
  logic [6:0]  m_shift_q, m_shift_d;

  // arbiter and bus sequencer
  arb_state_t  state_q, state_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic        g;
  logic [11:0] hdr;
  logic [7:0]  m_last;
  logic        bus_line;
  logic [2:0]  dw, dr;

  // slave side: header deserializer, address counter, data deserializer
  logic [11:0] s_hdr_q, s_hdr_d;
  logic [11:0] hdr_full;
  logic [3:0]  s_addr_q, s_addr_d;
  logic [6:0]  s_shift_q, s_shift_d;
  logic        s_valid, s_rw, s_mapped;
  logic [1:0]  s_sel;
  logic [7:0]  s_last;
  logic [7:0]  mem_q [3][16];
  logic [7:0]  mem_d [3][16];

  assign tick       = enable && (cnt_q == CNT_MAX);
  assign scaled_clk = (cnt_q < CNT_HALF);
  assign m1_busy    = busy_q[0];
  assign m2_busy    = busy_q[1];

  assign btn_now   = ~{button3_raw, button2_raw, button1_raw};
  assign btn_press = btn_now & ~btn_prev_q;
  assign rw_in     = {rw_switch2, rw_switch1};

  // The granted master's frame: start, slave, rw, addr, len. The last bit
  // index of a transfer is 12 + 8N = 20 + 8*len.
  assign g      = (state_q == GRANT2);
  assign hdr    = {1'b1, sel_q[g], rw_q[g], addr_q[g], len_q[g]};
  assign m_last = 8'd20 + {1'b0, len_q[g], 3'b000};

  // Bit position inside the current data byte: write data starts at bit 12,
  // read data at bit 13, so only the low three bits need offsetting.
  assign dw = bit_cnt_q[2:0] + 3'd4;
  assign dr = bit_cnt_q[2:0] + 3'd3;

  // The slave works only from what it deserialized off the line.
  assign hdr_full = {s_hdr_q[10:0], bus_line};
  assign s_valid  = s_hdr_q[11];
  assign s_sel    = s_hdr_q[10:9];
  assign s_rw     = s_hdr_q[8];
  assign s_mapped = (s_sel != 2'd3);
  assign s_last   = 8'd20 + {1'b0, s_hdr_q[3:0], 3'b000};

  // Shared serial line: master drives header and write data, the slave
  // drives read data and the write ack; otherwise the line idles high.
  // An unmapped slave never pulls the line, so reads see 0xFF.
  always_comb begin
    bus_line = 1'b1;
    if (state_q != IDLE) begin
      if (bit_cnt_q < 8'd12) begin
        bus_line = hdr[4'd11 - bit_cnt_q[3:0]];
      end else if (!rw_q[g] && bit_cnt_q < m_last) begin
        bus_line = wdata_q[g][3'd7 - dw];
      end else if (s_valid && s_rw && bit_cnt_q >= 8'd13 && bit_cnt_q <= s_last) begin
        bus_line = s_mapped ? mem_q[s_sel][s_addr_q][3'd7 - dr] : 1'b1;
      end else if (s_valid && !s_rw && bit_cnt_q == s_last) begin
        bus_line = s_mapped;
      end
    end
  end

  // Next-state logic for divider, buttons, config, masters, arbiter and slaves.
  always_comb begin
    cnt_d      = cnt_q;
    btn_prev_d = btn_prev_q;
    idx_d      = idx_q;
    cfg_d      = cfg_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    len_d      = len_q;
    rdata_d    = rdata_q;
    m_shift_d  = m_shift_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    s_hdr_d    = s_hdr_q;
    s_addr_d   = s_addr_q;
    s_shift_d  = s_shift_q;
    mem_d      = mem_q;

    if (enable) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    if (tick) begin
      btn_prev_d = btn_now;

      // Config stepping is level based: a held button steps every tick.
      if (!mode_switch && btn_now[2]) begin
        cfg_d[idx_q] = switch_array;
        idx_d = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
      end

      if (state_q == IDLE) begin
        if (busy_q[0]) begin
          state_d   = GRANT1;
          bit_cnt_d = '0;
        end else if (busy_q[1]) begin
          state_d   = GRANT2;
          bit_cnt_d = '0;
        end
      end else begin
        if (bit_cnt_q < 8'd12) begin
          s_hdr_d = hdr_full;
          if (bit_cnt_q == 8'd11) begin
            s_addr_d = hdr_full[7:4];
          end
        end else begin
          if (s_valid && !s_rw && bit_cnt_q < s_last) begin
            s_shift_d = {s_shift_q[5:0], bus_line};
            if (dw == 3'd7) begin
              if (s_mapped) begin
                mem_d[s_sel][s_addr_q] = {s_shift_q, bus_line};
              end
              s_addr_d = s_addr_q + 4'd1;
            end
          end
          if (s_valid && s_rw && bit_cnt_q >= 8'd13 && bit_cnt_q <= s_last && dr == 3'd7) begin
            s_addr_d = s_addr_q + 4'd1;
          end
          if (rw_q[g] && bit_cnt_q >= 8'd13 && bit_cnt_q <= m_last) begin
            m_shift_d = {m_shift_q[5:0], bus_line};
            if (dr == 3'd7) begin
              rdata_d[g] = {m_shift_q, bus_line};
            end
          end
        end

        // On completion the waiting master, if any, is granted straight away
        // so it starts on the very next bit-time.
        if (bit_cnt_q == m_last) begin
          busy_d[g] = 1'b0;
          bit_cnt_d = '0;
          if (busy_q[~g]) begin
            state_d = g ? GRANT1 : GRANT2;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end

      if (mode_switch) begin
        for (int m = 0; m < 2; m++) begin
          if (btn_press[m] && !busy_q[m]) begin
            busy_d[m]  = 1'b1;
            rw_d[m]    = rw_in[m];
            addr_d[m]  = cfg_q[3*m][3:0];
            wdata_d[m] = cfg_q[3*m+1][7:0];
            sel_d[m]   = cfg_q[3*m+2][1:0];
            len_d[m]   = cfg_q[3*m+2][7:4];
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      btn_prev_q <= '0;
      idx_q      <= '0;
      busy_q     <= '0;
      rw_q       <= '0;
      m_shift_q  <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      s_hdr_q    <= '0;
      s_addr_q   <= '0;
      s_shift_q  <= '0;
      for (int i = 0; i < 7; i++) cfg_q[i] <= '0;
      for (int m = 0; m < 2; m++) begin
        addr_q[m]  <= '0;
        wdata_q[m] <= '0;
        sel_q[m]   <= '0;
        len_q[m]   <= '0;
        rdata_q[m] <= '0;
      end
      for (int s = 0; s < 3; s++) begin
        for (int a = 0; a < 16; a++) mem_q[s][a] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      idx_q      <= idx_d;
      cfg_q      <= cfg_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      rdata_q    <= rdata_d;
      m_shift_q  <= m_shift_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      s_hdr_q    <= s_hdr_d;
      s_addr_q   <= s_addr_d;
      s_shift_q  <= s_shift_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_serial_bus_top.sv
// tb_serial_bus_top
//   Directed bench for serial_bus_top with SCALE=10. Busy durations are
//   measured in clock cycles (10 per bus bit-time) and internal registers
//   (config, memories, read data) are probed hierarchically.
`timescale 1ns/1ps

module tb_serial_bus_top;

  logic        clock = 1'b0;
  logic        rst;
  logic        enable;
  logic        button1_raw;
  logic        button2_raw;
  logic        button3_raw;
  logic        mode_switch;
  logic        rw_switch1;
  logic        rw_switch2;
  logic [11:0] switch_array;
  logic        m1_busy;
  logic        m2_busy;
  logic        scaled_clk;

  int checkCount = 0;
  int errorCount = 0;
  int hi1, hi2;

  serial_bus_top #(.SCALE(10)) dut (
    .clock        (clock),
    .rst          (rst),
    .enable       (enable),
    .button1_raw  (button1_raw),
    .button2_raw  (button2_raw),
    .button3_raw  (button3_raw),
    .mode_switch  (mode_switch),
    .rw_switch1   (rw_switch1),
    .rw_switch2   (rw_switch2),
    .switch_array (switch_array),
    .m1_busy      (m1_busy),
    .m2_busy      (m2_busy),
    .scaled_clk   (scaled_clk)
  );

  // 10 ns system clock
  always #5 clock = ~clock;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Holds button3 low for the given number of bit-times with a fixed value.
  task automatic configStep(input logic [11:0] value, input int ticks);
    mode_switch  = 1'b0;
    switch_array = value;
    button3_raw  = 1'b0;
    waitClocks(10 * ticks);
  endtask

  // Presses the selected start buttons for one bit-time and counts the
  // clock cycles each busy flag is high until both masters are idle.
  // Optionally re-presses button1 and/or freezes the divider mid-run.
  task automatic applyStimulus(input logic mode, input logic b1, input logic b2,
                               input int pressAgainAt, input int freezeAt,
                               input int freezeLen, output int h1, output int h2);
    logic done;
    h1 = 0;
    h2 = 0;
    done = 1'b0;
    mode_switch = mode;
    button1_raw = ~b1;
    button2_raw = ~b2;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      h1 += int'(m1_busy);
      h2 += int'(m2_busy);
      if (cyc == 9) begin
        button1_raw = 1'b1;
        button2_raw = 1'b1;
      end
      if (cyc == pressAgainAt) button1_raw = 1'b0;
      if (cyc == pressAgainAt + 10) button1_raw = 1'b1;
      if (cyc == freezeAt) enable = 1'b0;
      if (cyc == freezeAt + freezeLen) enable = 1'b1;
      if (cyc > 20 && !m1_busy && !m2_busy && enable) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("txnCompleted", 32'(done), 32'd1);
  endtask

  initial begin
    int firstRise, secondRise, hiCount;
    logic prevSc;

    rst = 1'b1;
    enable = 1'b1;
    button1_raw = 1'b1;
    button2_raw = 1'b1;
    button3_raw = 1'b1;
    mode_switch = 1'b0;
    rw_switch1 = 1'b0;
    rw_switch2 = 1'b0;
    switch_array = '0;

    // Reset state
    waitClocks(3);
    checkOutput("resetM1Busy", 32'(m1_busy), 32'd0);
    checkOutput("resetM2Busy", 32'(m2_busy), 32'd0);
    checkOutput("resetScaledClk", 32'(scaled_clk), 32'd1);
    checkOutput("resetIdx", 32'(dut.idx_q), 32'd0);
    rst = 1'b0;

    // Divider: period 10 clocks, 5 high
    firstRise = -1;
    secondRise = -1;
    hiCount = 0;
    prevSc = scaled_clk;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!prevSc && scaled_clk) begin
        if (firstRise < 0) firstRise = i;
        else if (secondRise < 0) secondRise = i;
      end
      if (firstRise >= 0 && secondRise < 0 && scaled_clk) hiCount++;
      prevSc = scaled_clk;
    end
    checkOutput("scaledClkPeriod", 32'(secondRise - firstRise), 32'd10);
    checkOutput("scaledClkHigh", 32'(hiCount), 32'd5);

    // Config load: 5 steps of 10, 2 steps of 0 -> wraps back to index 0
    configStep(12'd10, 5);
    configStep(12'd0, 2);
    button3_raw = 1'b1;
    waitClocks(10);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("cfgLoadR%0d", i), 32'(dut.cfg_q[i]), (i < 5) ? 32'd10 : 32'd0);
    end
    checkOutput("cfgIdxWrap", 32'(dut.idx_q), 32'd0);

    // Start buttons are ignored in config mode
    applyStimulus(1'b0, 1'b1, 1'b0, -1, -1, 0, hi1, hi2);
    checkOutput("cfgModeIgnoresB1", 32'(hi1), 32'd0);

    // Single write: slave 2, addr 10, N=1 -> 22 bit-times busy
    rw_switch1 = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, -1, -1, 0, hi1, hi2);
    checkOutput("singleWriteBusy", 32'(hi1), 32'd220);
    checkOutput("singleWriteM2Idle", 32'(hi2), 32'd0);
    checkOutput("singleWriteMem", 32'(dut.mem_q[2][10]), 32'h0A);

    // Single read back
    rw_switch1 = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, -1, -1, 0, hi1, hi2);
    checkOutput("singleReadBusy", 32'(hi1), 32'd220);
    checkOutput("singleReadData", 32'(dut.rdata_q[0]), 32'h0A);

    // Contention: M1 wins, M2 finishes 21 bit-times later; repeat press ignored
    rw_switch1 = 1'b0;
    rw_switch2 = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 100, -1, 0, hi1, hi2);
    checkOutput("contentionM1Busy", 32'(hi1), 32'd220);
    checkOutput("contentionM2Busy", 32'(hi2), 32'd430);
    checkOutput("contentionM2Mem", 32'(dut.mem_q[0][10]), 32'h0A);

    // Enable low for 50 clocks mid-transfer stretches busy by 50 clocks
    rw_switch1 = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, -1, 60, 50, hi1, hi2);
    checkOutput("freezeBusy", 32'(hi1), 32'd270);
    checkOutput("freezeReadData", 32'(dut.rdata_q[0]), 32'h0A);

    // Burst config: addr 14 (wraps), data 0x5A, slave 1 len 8 (N=9)
    configStep(12'd14, 1);
    configStep(12'h05A, 1);
    configStep(12'h081, 1);
    button3_raw = 1'b1;
    waitClocks(10);
    checkOutput("burstCfgIdx", 32'(dut.idx_q), 32'd3);

    rw_switch1 = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, -1, -1, 0, hi1, hi2);
    checkOutput("burstWriteBusy", 32'(hi1), 32'd860);
    checkOutput("burstMem14", 32'(dut.mem_q[1][14]), 32'h5A);
    checkOutput("burstMem15", 32'(dut.mem_q[1][15]), 32'h5A);
    checkOutput("burstMem0", 32'(dut.mem_q[1][0]), 32'h5A);
    checkOutput("burstMem6", 32'(dut.mem_q[1][6]), 32'h5A);
    checkOutput("burstMem7Untouched", 32'(dut.mem_q[1][7]), 32'h00);
    checkOutput("burstMem13Untouched", 32'(dut.mem_q[1][13]), 32'h00);

    rw_switch1 = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, -1, -1, 0, hi1, hi2);
    checkOutput("burstReadBusy", 32'(hi1), 32'd860);
    checkOutput("burstReadData", 32'(dut.rdata_q[0]), 32'h5A);

    // M2 to unmapped slave 3: addr 5, data 0x33, N=1
    configStep(12'd5, 1);
    configStep(12'h033, 1);
    configStep(12'h003, 1);
    button3_raw = 1'b1;
    waitClocks(10);
    rw_switch2 = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, -1, -1, 0, hi1, hi2);
    checkOutput("unmappedReadBusy", 32'(hi2), 32'd220);
    checkOutput("unmappedReadData", 32'(dut.rdata_q[1]), 32'hFF);
    rw_switch2 = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, -1, -1, 0, hi1, hi2);
    checkOutput("unmappedWriteBusy", 32'(hi2), 32'd220);
    checkOutput("unmappedSlave0Clean", 32'(dut.mem_q[0][5]), 32'h00);
    checkOutput("unmappedSlave2Clean", 32'(dut.mem_q[2][5]), 32'h00);

    // Reset mid-burst clears busy without waiting for a clock edge
    rw_switch1 = 1'b0;
    mode_switch = 1'b1;
    button1_raw = 1'b0;
    waitClocks(10);
    button1_raw = 1'b1;
    waitClocks(290);
    checkOutput("midBurstBusy", 32'(m1_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncResetBusy", 32'(m1_busy), 32'd0);
    checkOutput("asyncResetMem", 32'(dut.mem_q[1][14]), 32'h00);
    checkOutput("asyncResetCfg", 32'(dut.cfg_q[2]), 32'd0);
    checkOutput("asyncResetScaledClk", 32'(scaled_clk), 32'd1);
    waitClocks(2);
    rst = 1'b0;
    waitClocks(2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
